// File: rtl/sensor_link_if.sv
// Byte-level UART handshake between the sensor responder and its UART.
// The master side is the UART; the slave side is the responder.
interface sensor_link_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_rdy_clr;
    logic [7:0] tx_data;
    logic       tx_wr_en;
    logic       tx_busy;

    modport master (
        output rx_data,
        output rx_rdy,
        output tx_busy,
        input  rx_rdy_clr,
        input  tx_data,
        input  tx_wr_en
    );

    modport slave (
        input  rx_data,
        input  rx_rdy,
        input  tx_busy,
        output rx_rdy_clr,
        output tx_data,
        output tx_wr_en
    );
endinterface

// File: rtl/sensor_link_responder.sv
// sensor_link_responder: sensor-side end of the request/response UART link.
// Answers each nonzero request byte with {value, value ^ CHECK_KEY} and
// repeats alarm frames {0x00, CHECK_KEY} until the host sends a 0x00 byte.
module sensor_link_responder #(
    parameter logic [7:0] CHECK_KEY    = 8'h37,
    parameter int         ALARM_PERIOD = 1000,
    parameter int         CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    sensor_link_if.slave     link,
    input  logic [7:0]       i_sensor_data,
    input  logic             i_alarm_in,
    input  logic             i_err_inject,
    output logic             o_alarm_active,
    output logic             o_busy,
    output logic [7:0]       o_last_req,
    output logic [CNT_W-1:0] o_frame_count
);

    localparam int                GAP_W      = (ALARM_PERIOD > 1) ? $clog2(ALARM_PERIOD + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_ZERO   = GAP_W'(0);
    localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(ALARM_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    // Cycles spent in a WAIT state before a silent transmitter is assumed done.
    localparam logic [1:0]        WAIT_LIMIT = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD0 = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_LOAD1 = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    // Checksum byte: value keyed with CHECK_KEY, bit0 flipped when corrupting.
    function automatic logic [7:0] checksum_f(input logic [7:0] value, input logic corrupt);
        return value ^ CHECK_KEY ^ {7'b0000000, corrupt};
    endfunction

    logic [2:0]       r_state;
    logic [7:0]       r_value;
    logic [7:0]       r_check;
    logic             r_is_alarm;
    logic [1:0]       r_wait_cnt;
    logic             r_busy_seen;
    logic             r_alarm_prev;
    logic             r_alarm_active;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_rx_rdy_clr;
    logic             r_tx_wr_en;
    logic [7:0]       r_tx_data;
    logic             r_busy;
    logic [7:0]       r_last_req;
    logic [CNT_W-1:0] r_frame_count;

    logic [2:0]       w_state_nxt;
    logic             w_load;
    logic             w_load_alarm;
    logic [7:0]       w_value;
    logic             w_consume;
    logic             w_silence;
    logic             w_gap_dec;
    logic             w_send;
    logic             w_frame_end;
    logic             w_wait_done;
    logic             w_alarm_rise;
    logic             w_in_wait;

    // A byte is done once busy was seen and dropped, or busy never came up.
    assign w_wait_done  = !link.tx_busy && (r_busy_seen || (r_wait_cnt == WAIT_LIMIT));
    assign w_alarm_rise = i_alarm_in && !r_alarm_prev;
    assign w_in_wait    = (r_state == S_WAIT0) || (r_state == S_WAIT1);

    // Next-state and per-cycle action decode; alarm outranks pending requests.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_load_alarm = 1'b0;
        w_value      = 8'h00;
        w_consume    = 1'b0;
        w_silence    = 1'b0;
        w_gap_dec    = 1'b0;
        w_send       = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_alarm_active && (r_gap_cnt == GAP_ZERO)) begin
                    w_load       = 1'b1;
                    w_load_alarm = 1'b1;
                    w_value      = 8'h00;
                    w_state_nxt  = S_LOAD0;
                end else if (link.rx_rdy && !r_rx_rdy_clr) begin
                    // r_rx_rdy_clr guards against re-reading a byte the UART has not yet dropped.
                    w_consume = 1'b1;
                    if (link.rx_data == 8'h00) begin
                        w_silence = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_value     = (i_sensor_data == 8'h00) ? 8'h01 : i_sensor_data;
                        w_state_nxt = S_LOAD0;
                    end
                end else begin
                    w_gap_dec = (r_gap_cnt != GAP_ZERO);
                end
            end
            S_LOAD0, S_LOAD1: begin
                if (!link.tx_busy) begin
                    w_send      = 1'b1;
                    w_state_nxt = (r_state == S_LOAD0) ? S_WAIT0 : S_WAIT1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_WAIT0: begin
                if (w_wait_done) begin
                    w_state_nxt = S_LOAD1;
                end else begin
                    w_state_nxt = S_WAIT0;
                end
            end
            S_WAIT1: begin
                if (w_wait_done) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = r_is_alarm ? S_GAP : S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and the registered UART-facing strobes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_rx_rdy_clr <= 1'b0;
            r_tx_wr_en   <= 1'b0;
            r_tx_data    <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_rx_rdy_clr <= w_consume;
            r_tx_wr_en   <= w_send;
            if (w_send) begin
                r_tx_data <= (r_state == S_LOAD0) ? r_value : r_check;
            end
        end
    end

    // Capture the frame bytes; err_inject is sampled together with the value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_value    <= 8'h00;
            r_check    <= 8'h00;
            r_is_alarm <= 1'b0;
        end else if (w_load) begin
            r_value    <= w_value;
            r_check    <= checksum_f(w_value, i_err_inject);
            r_is_alarm <= w_load_alarm;
        end
    end

    // Track tx_busy after each write strobe, with a timeout for a silent UART.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt  <= 2'd0;
            r_busy_seen <= 1'b0;
        end else if (w_send) begin
            r_wait_cnt  <= 2'd0;
            r_busy_seen <= 1'b0;
        end else if (w_in_wait) begin
            if (link.tx_busy) begin
                r_busy_seen <= 1'b1;
            end
            if (r_wait_cnt != WAIT_LIMIT) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end
        end
    end

    // Alarm arming on a rising edge, silencing by 0x00, and the repeat gap timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_alarm_prev   <= 1'b0;
            r_alarm_active <= 1'b0;
            r_gap_cnt      <= GAP_ZERO;
        end else begin
            r_alarm_prev <= i_alarm_in;
            if (w_alarm_rise) begin
                r_alarm_active <= 1'b1;
            end else if (w_silence) begin
                r_alarm_active <= 1'b0;
            end
            if (w_silence) begin
                r_gap_cnt <= GAP_ZERO;
            end else if (w_frame_end && r_is_alarm) begin
                r_gap_cnt <= GAP_RELOAD;
            end else if (w_gap_dec) begin
                r_gap_cnt <= r_gap_cnt - GAP_ONE;
            end
        end
    end

    // Status: last accepted request and count of completed frames (wraps).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_req    <= 8'h00;
            r_frame_count <= CNT_ZERO;
        end else begin
            if (w_consume && !w_silence) begin
                r_last_req <= link.rx_data;
            end
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + CNT_ONE;
            end
        end
    end

    assign link.rx_rdy_clr = r_rx_rdy_clr;
    assign link.tx_wr_en   = r_tx_wr_en;
    assign link.tx_data    = r_tx_data;
    assign o_alarm_active  = r_alarm_active;
    assign o_busy          = r_busy;
    assign o_last_req      = r_last_req;
    assign o_frame_count   = r_frame_count;

endmodule

// File: tb/tb_sensor_link_responder.sv
// Testbench for sensor_link_responder: UART model plus frame-level reference.
module tb_sensor_link_responder;
    localparam logic [7:0] KEY    = 8'h37;
    localparam int         PERIOD = 20;
    localparam int         CW     = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    sensor_data;
    logic          alarm_in;
    logic          err_inject;
    logic          alarm_active;
    logic          dut_busy;
    logic [7:0]    last_req;
    logic [CW-1:0] frame_count;

    sensor_link_if link();

    sensor_link_responder #(.CHECK_KEY(KEY), .ALARM_PERIOD(PERIOD), .CNT_W(CW)) dut (
        .clock          (clock),
        .reset          (reset),
        .link           (link),
        .i_sensor_data  (sensor_data),
        .i_alarm_in     (alarm_in),
        .i_err_inject   (err_inject),
        .o_alarm_active (alarm_active),
        .o_busy         (dut_busy),
        .o_last_req     (last_req),
        .o_frame_count  (frame_count)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            busy_len = 1;
    int            busy_left = 0;
    int            clr_count = 0;
    int            violations = 0;
    int            rx_present_cyc = 0;
    logic [7:0]    rx_q[$];
    logic [7:0]    tx_bytes[$];
    int            tx_cyc[$];
    logic [7:0]    exp_bytes[$];
    logic [CW-1:0] exp_count = '0;

    always @(posedge clock) cyc <= cyc + 1;

    // UART model: presents queued rx bytes, logs tx bytes, holds tx_busy busy_len cycles.
    always @(negedge clock) begin
        if (reset) begin
            link.rx_rdy  = 1'b0;
            link.rx_data = 8'h00;
            link.tx_busy = 1'b0;
            busy_left    = 0;
        end else begin
            if (link.tx_wr_en) begin
                if (link.tx_busy) violations++;
                tx_bytes.push_back(link.tx_data);
                tx_cyc.push_back(cyc);
                if (busy_len > 0) begin
                    link.tx_busy = 1'b1;
                    busy_left    = busy_len;
                end
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) link.tx_busy = 1'b0;
            end
            if (link.rx_rdy_clr) begin
                clr_count++;
                link.rx_rdy = 1'b0;
            end else if (!link.rx_rdy && rx_q.size() > 0) begin
                link.rx_data   = rx_q.pop_front();
                link.rx_rdy    = 1'b1;
                rx_present_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: response value for a sensor reading (0x00 is reserved).
    function automatic logic [7:0] resp_value(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    task automatic expect_frame(input logic [7:0] v, input logic e);
        exp_bytes.push_back(v);
        exp_bytes.push_back(v ^ KEY ^ {7'b0000000, e});
        exp_count = exp_count + 1'b1;
    endtask

    task automatic clear_logs();
        tx_bytes.delete(); tx_cyc.delete(); exp_bytes.delete();
        clr_count = 0; violations = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        int quiet;
        quiet = 0; ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock); #1;
            if (!dut_busy && rx_q.size() == 0 && !link.rx_rdy && !link.tx_busy) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_tx(input int n, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock); #1;
            if (tx_bytes.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        if ({link.tx_wr_en, link.rx_rdy_clr, link.tx_data, alarm_active, dut_busy, last_req, frame_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got wr=%b clr=%b txd=%h al=%b busy=%b last=%h cnt=%0d exp all 0",
                     link.tx_wr_en, link.rx_rdy_clr, link.tx_data, alarm_active, dut_busy, last_req, frame_count);
        end
        checks++;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        if ({link.tx_wr_en, link.rx_rdy_clr, dut_busy, frame_count} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle got wr=%b clr=%b busy=%b cnt=%0d exp 0", link.tx_wr_en, link.rx_rdy_clr, dut_busy, frame_count);
        end
        checks++;
    endtask

    task automatic test_request();
        bit ok;
        clear_logs(); busy_len = 1; sensor_data = 8'h5A; err_inject = 1'b0;
        exp_bytes.push_back(8'h5A); exp_bytes.push_back(8'h6D); exp_count = exp_count + 1'b1;
        send_byte(8'h80);
        wait_idle(300, ok);
        if (!ok) begin failures++; $display("FAIL req_timeout got busy=%b exp idle", dut_busy); end
        checks++;
        if (tx_bytes.size() != 2) begin failures++; $display("FAIL req_wr_pulses got=%0d exp=2", tx_bytes.size()); end
        else for (int i = 0; i < 2; i++) begin
            if (tx_bytes[i] !== exp_bytes[i]) begin failures++; $display("FAIL req_byte%0d got=%h exp=%h", i, tx_bytes[i], exp_bytes[i]); end
            checks++;
        end
        checks++;
        if (tx_cyc.size() == 0 || tx_cyc[0] - rx_present_cyc != 2) begin
            failures++; $display("FAIL req_latency got=%0d exp=2", (tx_cyc.size() > 0) ? tx_cyc[0] - rx_present_cyc : -1);
        end
        checks++;
        if (last_req !== 8'h80) begin failures++; $display("FAIL req_last_req got=%h exp=80", last_req); end
        checks++;
        if (frame_count !== 4'd1) begin failures++; $display("FAIL req_frame_count got=%0d exp=1", frame_count); end
        checks++;
        if (clr_count != 1) begin failures++; $display("FAIL req_clr_pulses got=%0d exp=1", clr_count); end
        checks++;
    endtask

    task automatic test_zero_clamp_err();
        bit ok;
        for (int e = 0; e < 2; e++) begin
            clear_logs(); busy_len = 2; sensor_data = 8'h00; err_inject = e[0];
            exp_bytes.push_back(8'h01); exp_bytes.push_back((e == 0) ? 8'h36 : 8'h37); exp_count = exp_count + 1'b1;
            send_byte(8'h01);
            wait_idle(300, ok);
            if (!ok || tx_bytes.size() != 2) begin
                failures++; $display("FAIL clamp_err%0d_count got=%0d exp=2 ok=%b", e, tx_bytes.size(), ok);
            end else for (int i = 0; i < 2; i++) begin
                if (tx_bytes[i] !== exp_bytes[i]) begin failures++; $display("FAIL clamp_err%0d_byte%0d got=%h exp=%h", e, i, tx_bytes[i], exp_bytes[i]); end
                checks++;
            end
            checks++;
            if (frame_count !== exp_count) begin failures++; $display("FAIL clamp_err%0d_frame_count got=%0d exp=%0d", e, frame_count, exp_count); end
            checks++;
        end
        err_inject = 1'b0;
    endtask

    task automatic test_silence_idle();
        bit ok;
        clear_logs(); busy_len = 1;
        send_byte(8'h00);
        wait_idle(100, ok);
        if (!ok || clr_count != 1 || tx_bytes.size() != 0) begin
            failures++; $display("FAIL silence_idle got clr=%0d tx=%0d ok=%b exp clr=1 tx=0", clr_count, tx_bytes.size(), ok);
        end
        checks++;
        if (frame_count !== exp_count || last_req !== 8'h01 || alarm_active !== 1'b0) begin
            failures++; $display("FAIL silence_state got cnt=%0d last=%h al=%b exp cnt=%0d last=01 al=0", frame_count, last_req, alarm_active, exp_count);
        end
        checks++;
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] req;
        for (int n = 0; n < 20; n++) begin
            clear_logs();
            busy_len    = $urandom_range(0, 4);
            sensor_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            err_inject  = 1'($urandom_range(0, 1));
            req         = 8'($urandom_range(1, 255));
            expect_frame(resp_value(sensor_data), err_inject);
            send_byte(req);
            wait_idle(300, ok);
            if (!ok || tx_bytes.size() != 2 || clr_count != 1) begin
                failures++; $display("FAIL rand%0d_pulses got tx=%0d clr=%0d ok=%b exp tx=2 clr=1", n, tx_bytes.size(), clr_count, ok);
            end else for (int i = 0; i < 2; i++) begin
                if (tx_bytes[i] !== exp_bytes[i]) begin failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", n, i, tx_bytes[i], exp_bytes[i]); end
                checks++;
            end
            checks++;
            if (last_req !== req || frame_count !== exp_count) begin
                failures++; $display("FAIL rand%0d_status got last=%h cnt=%0d exp last=%h cnt=%0d", n, last_req, frame_count, req, exp_count);
            end
            checks++;
        end
        err_inject = 1'b0;
    endtask

    task automatic test_alarm();
        bit ok;
        clear_logs(); busy_len = 1;
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h37);
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h37);
        exp_count = exp_count + 2'd2;
        alarm_in = 1'b1;
        @(negedge clock); #1;
        if (alarm_active !== 1'b1) begin failures++; $display("FAIL alarm_arm got=%b exp=1", alarm_active); end
        checks++;
        repeat (4) @(negedge clock);
        alarm_in = 1'b0;
        wait_tx(4, 300, ok);
        if (!ok) begin failures++; $display("FAIL alarm_repeat_timeout got tx=%0d exp=4", tx_bytes.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                if (tx_bytes[i] !== exp_bytes[i]) begin failures++; $display("FAIL alarm_byte%0d got=%h exp=%h", i, tx_bytes[i], exp_bytes[i]); end
                checks++;
            end
            if (tx_cyc[2] - tx_cyc[1] < PERIOD || tx_cyc[2] - tx_cyc[1] > PERIOD + 10) begin
                failures++; $display("FAIL alarm_gap got=%0d exp %0d..%0d", tx_cyc[2] - tx_cyc[1], PERIOD, PERIOD + 10);
            end
            checks++;
        end
        checks++;
        if (alarm_active !== 1'b1) begin failures++; $display("FAIL alarm_held got=%b exp=1", alarm_active); end
        checks++;
        send_byte(8'h00);
        repeat (80) @(negedge clock);
        #1;
        if (alarm_active !== 1'b0 || tx_bytes.size() != 4) begin
            failures++; $display("FAIL alarm_silence got al=%b tx=%0d exp al=0 tx=4", alarm_active, tx_bytes.size());
        end
        checks++;
        if (frame_count !== exp_count) begin failures++; $display("FAIL alarm_frame_count got=%0d exp=%0d", frame_count, exp_count); end
        checks++;
    endtask

    task automatic test_alarm_mid_frame();
        bit ok;
        clear_logs(); busy_len = 8; sensor_data = 8'h3C; err_inject = 1'b0;
        expect_frame(8'h3C, 1'b0);
        expect_frame(8'h00, 1'b0);
        expect_frame(8'h3C, 1'b0);
        send_byte(8'h11);
        wait_tx(1, 100, ok);
        alarm_in = 1'b1;
        send_byte(8'h22);
        wait_tx(3, 200, ok);
        alarm_in = 1'b0;
        wait_tx(6, 300, ok);
        send_byte(8'h00);
        wait_idle(300, ok);
        if (!ok || tx_bytes.size() != 6) begin
            failures++; $display("FAIL mid_count got=%0d exp=6 ok=%b", tx_bytes.size(), ok);
        end else for (int i = 0; i < 6; i++) begin
            if (tx_bytes[i] !== exp_bytes[i]) begin failures++; $display("FAIL mid_byte%0d got=%h exp=%h", i, tx_bytes[i], exp_bytes[i]); end
            checks++;
        end
        checks++;
        if (last_req !== 8'h22 || alarm_active !== 1'b0 || frame_count !== exp_count) begin
            failures++; $display("FAIL mid_status got last=%h al=%b cnt=%0d exp last=22 al=0 cnt=%0d", last_req, alarm_active, frame_count, exp_count);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs(); busy_len = 50; sensor_data = 8'hC3;
        expect_frame(8'hC3, 1'b0);
        send_byte(8'h05);
        wait_idle(500, ok);
        if (!ok || tx_bytes.size() != 2 || violations != 0) begin
            failures++; $display("FAIL bp_pulses got tx=%0d viol=%0d ok=%b exp tx=2 viol=0", tx_bytes.size(), violations, ok);
        end else begin
            if (tx_cyc[1] - tx_cyc[0] < 50) begin failures++; $display("FAIL bp_spacing got=%0d exp>=50", tx_cyc[1] - tx_cyc[0]); end
            checks++;
            if (tx_bytes[1] !== exp_bytes[1]) begin failures++; $display("FAIL bp_check got=%h exp=%h", tx_bytes[1], exp_bytes[1]); end
            checks++;
        end
        checks++;
    endtask

    task automatic test_stuck_low();
        bit ok;
        clear_logs(); busy_len = 0; sensor_data = 8'h77;
        expect_frame(8'h77, 1'b0);
        send_byte(8'h09);
        wait_idle(200, ok);
        if (!ok || tx_bytes.size() != 2) begin
            failures++; $display("FAIL stuck_count got=%0d exp=2 ok=%b", tx_bytes.size(), ok);
        end else begin
            if (tx_cyc[1] - tx_cyc[0] < 4 || tx_cyc[1] - tx_cyc[0] > 6) begin
                failures++; $display("FAIL stuck_spacing got=%0d exp 4..6", tx_cyc[1] - tx_cyc[0]);
            end
            checks++;
            if (tx_bytes[0] !== 8'h77 || tx_bytes[1] !== 8'h40) begin
                failures++; $display("FAIL stuck_bytes got=%h,%h exp=77,40", tx_bytes[0], tx_bytes[1]);
            end
            checks++;
        end
        checks++;
        if (frame_count !== exp_count) begin failures++; $display("FAIL stuck_frame_count got=%0d exp=%0d", frame_count, exp_count); end
        checks++;
    endtask

    task automatic test_reset_mid_wait0();
        bit ok;
        clear_logs(); busy_len = 50; sensor_data = 8'h10;
        send_byte(8'h33);
        wait_tx(1, 100, ok);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #1;
        if ({link.tx_wr_en, link.rx_rdy_clr, link.tx_data, alarm_active, dut_busy, last_req, frame_count} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got wr=%b clr=%b txd=%h al=%b busy=%b last=%h cnt=%0d exp all 0",
                     link.tx_wr_en, link.rx_rdy_clr, link.tx_data, alarm_active, dut_busy, last_req, frame_count);
        end
        checks++;
        repeat (2) @(negedge clock);
        rx_q.delete();
        reset = 1'b0;
        exp_count = '0;
        clear_logs(); busy_len = 2; sensor_data = 8'h44;
        expect_frame(8'h44, 1'b0);
        send_byte(8'h66);
        wait_idle(300, ok);
        if (!ok || tx_bytes.size() != 2) begin
            failures++; $display("FAIL midreset_next_count got=%0d exp=2 ok=%b", tx_bytes.size(), ok);
        end else if (tx_bytes[0] !== exp_bytes[0] || tx_bytes[1] !== exp_bytes[1]) begin
            failures++; $display("FAIL midreset_next_bytes got=%h,%h exp=%h,%h", tx_bytes[0], tx_bytes[1], exp_bytes[0], exp_bytes[1]);
        end
        checks++;
        if (frame_count !== 4'd1 || last_req !== 8'h66) begin
            failures++; $display("FAIL midreset_status got cnt=%0d last=%h exp cnt=1 last=66", frame_count, last_req);
        end
        checks++;
    endtask

    initial begin
        reset       = 1'b1;
        sensor_data = 8'h00;
        alarm_in    = 1'b0;
        err_inject  = 1'b0;
        test_reset();
        test_request();
        test_zero_clamp_err();
        test_silence_idle();
        test_random();
        test_alarm();
        test_alarm_mid_frame();
        test_backpressure();
        test_stuck_low();
        test_reset_mid_wait0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
